icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch stage (PC -> instruction)
//  and a multi-cycle unified main memory. Hits return the instruction combinationally in the

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_if.sv | 32 +++
 rtl/icache_line_store.sv | 52 +++++
 rtl/icache.sv | 142 ++++++++++++++
 tb/tb_icache.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry, derived
// field widths and the fill FSM state encoding.
package icache_pkg;

  localparam int LINES          = 8;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W         = 16;

  localparam int INDEX_W = $clog2(LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
  localparam int LINE_W  = 16 * WORDS_PER_LINE;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

endpackage

// File: rtl/icache_if.sv
// Bundles the fetch-side and memory-side signals of the instruction cache.
//   slave  : the cache (takes addr/re/flush and memory replies, drives
//            instr/rdy, line requests and the hit/miss counters)
//   master : the environment (CPU fetch stage plus main memory)
interface icache_if #(
  parameter int ADDR_W = icache_pkg::ADDR_W,
  parameter int LINE_W = icache_pkg::LINE_W
);

  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              flush;
  logic [15:0]       instr;
  logic              rdy;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdy;
  logic [LINE_W-1:0] mem_rd_data;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport slave (
    input  addr, re, flush, mem_rdy, mem_rd_data,
    output instr, rdy, mem_re, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output addr, re, flush, mem_rdy, mem_rd_data,
    input  instr, rdy, mem_re, mem_addr, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the direct-mapped cache.
//   rd_idx                  -> rd_valid / rd_tag / rd_data : asynchronous read
//   wr_en, wr_idx, wr_tag,
//   wr_data, wr_valid       : synchronous whole-line write
//   clear_all               : synchronous invalidate of every line (wins over a write)
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module icache_line_store #(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 11,
  parameter int LINE_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic               wr_valid,
  input  logic               clear_all
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetch stage and a
// multi-cycle main memory. Hits return the instruction combinationally in
// the fetch cycle; a miss stalls fetch while one whole line is fetched.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus.addr/re/flush -> bus.instr/rdy  : fetch side
//   bus.mem_re/mem_addr <- bus.mem_rdy/mem_rd_data : line fill side
//   bus.hit_cnt/miss_cnt : saturating 16-bit statistics
module icache #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
);

  import icache_pkg::*;

  localparam int INDEX_W = $clog2(LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
  localparam int LINE_W  = 16 * WORDS_PER_LINE;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;

  state_t state, state_nx;
  logic   drop, drop_nx;

  // Line being filled; mem_addr is rebuilt from these so it is line-aligned by construction.
  logic [TAG_W-1:0]   fill_tag;
  logic [INDEX_W-1:0] fill_idx;

  logic [15:0] hit_cnt_q, miss_cnt_q;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;

  logic        rdy_c;
  logic [15:0] instr_c;
  logic        count_hit, count_miss, start_miss, fill_done;

  assign {tag, idx, off} = bus.addr;

  icache_line_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (fill_done),
    .wr_idx    (fill_idx),
    .wr_tag    (fill_tag),
    .wr_data   (bus.mem_rd_data),
    .wr_valid  (!drop),
    .clear_all (bus.flush)
  );

  // Lookup always uses the pre-flush valids; the flush only takes effect at the edge.
  assign hit = rd_valid && (rd_tag == tag);

  always_comb begin
    state_nx   = state;
    drop_nx    = drop;
    rdy_c      = 1'b0;
    instr_c    = '0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    start_miss = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        rdy_c = 1'b1;
        if (bus.re) begin
          if (hit) begin
            instr_c   = rd_data[off*16 +: 16];
            count_hit = 1'b1;
          end else begin
            rdy_c      = 1'b0;
            count_miss = 1'b1;
            start_miss = 1'b1;
            state_nx   = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rdy) begin
          // A flush on this same edge still invalidates: clear_all outranks the write.
          fill_done = 1'b1;
          drop_nx   = 1'b0;
          state_nx  = IDLE;
        end else if (bus.flush) begin
          drop_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (start_miss) begin
        fill_tag <= tag;
        fill_idx <= idx;
      end
      if (count_hit)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (count_miss) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign bus.rdy      = rdy_c && rst_n;
  assign bus.instr    = instr_c;
  assign bus.mem_re   = (state == WAIT);
  assign bus.mem_addr = {fill_tag, fill_idx, {OFF_W{1'b0}}};
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic clk;
  logic rst_n;

  icache_if #(.ADDR_W(16), .LINE_W(64)) bus ();

  icache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_bad;
  int lat;
  int req_cnt;
  logic mem_re_prev;

  // Memory content: every word is its own address XOR a fixed pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Main memory: answers in the lat-th cycle of a request.
  initial begin
    int cnt;
    logic [63:0] line;
    cnt = 0;
    bus.mem_rdy     = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_re) begin
        cnt++;
        if (cnt == lat) begin
          for (int w = 0; w < 4; w++)
            line[w*16 +: 16] = mem_word(bus.mem_addr | 16'(w));
          bus.mem_rd_data = line;
          bus.mem_rdy     = 1'b1;
        end else begin
          bus.mem_rdy = 1'b0;
        end
      end else begin
        cnt = 0;
        bus.mem_rdy = 1'b0;
      end
    end
  end

  // Counts line requests (rising edges of mem_re).
  initial begin
    req_cnt = 0;
    mem_re_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_re && !mem_re_prev) req_cnt++;
      mem_re_prev = bus.mem_re;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for rdy, counting stalled cycles, then steps past the completing edge.
  task automatic wait_rdy(output int stall, output logic [15:0] ins);
    bit seen;
    stall = 0;
    ins   = '0;
    seen  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.rdy) begin
        ins  = bus.instr;
        seen = 1'b1;
        break;
      end
      stall++;
    end
    if (!seen) $display("FAIL rdy_timeout: rdy never rose within 60 cycles");
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic do_access(input logic [15:0] a, input logic fl, input int l,
                           output int stall, output logic [15:0] ins);
    lat       = l;
    bus.addr  = a;
    bus.re    = 1'b1;
    bus.flush = fl;
    wait_rdy(stall, ins);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        flush;
    int          lat;
    int          stall;
    logic [15:0] instr;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  vec_t vt[13];

  initial begin
    int          st;
    logic [15:0] ins;
    int          req0;

    n_vec = 0;
    n_bad = 0;

    //            addr      fl  lat st  instr      hits    misses
    vt[0]  = '{16'h0012, 1'b0, 3, 4, 16'hC3B7, 16'd1,  16'd1};
    vt[1]  = '{16'h0010, 1'b0, 1, 0, 16'hC3B5, 16'd2,  16'd1};
    vt[2]  = '{16'h0011, 1'b0, 1, 0, 16'hC3B4, 16'd3,  16'd1};
    vt[3]  = '{16'h0013, 1'b0, 1, 0, 16'hC3B6, 16'd4,  16'd1};
    vt[4]  = '{16'h0032, 1'b0, 2, 3, 16'hC397, 16'd5,  16'd2};
    vt[5]  = '{16'h0012, 1'b0, 1, 2, 16'hC3B7, 16'd6,  16'd3};
    vt[6]  = '{16'h0012, 1'b0, 1, 0, 16'hC3B7, 16'd7,  16'd3};
    vt[7]  = '{16'h0012, 1'b1, 1, 0, 16'hC3B7, 16'd8,  16'd3};
    vt[8]  = '{16'h0012, 1'b0, 1, 2, 16'hC3B7, 16'd9,  16'd4};
    vt[9]  = '{16'h0035, 1'b0, 2, 3, 16'hC390, 16'd10, 16'd5};
    vt[10] = '{16'h8007, 1'b0, 1, 2, 16'h43A2, 16'd11, 16'd6};
    vt[11] = '{16'h0013, 1'b0, 1, 0, 16'hC3B6, 16'd12, 16'd6};
    vt[12] = '{16'h0035, 1'b0, 1, 0, 16'hC390, 16'd13, 16'd6};

    rst_n     = 1'b0;
    bus.addr  = '0;
    bus.re    = 1'b0;
    bus.flush = 1'b0;
    lat       = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy",      32'(bus.rdy),      32'd0);
    chk("reset_mem_re",   32'(bus.mem_re),   32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_hit_cnt",  32'(bus.hit_cnt),  32'd0);
    chk("reset_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("reset_instr",    32'(bus.instr),    32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_rdy_after_reset", 32'(bus.rdy), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      do_access(vt[i].addr, vt[i].flush, vt[i].lat, st, ins);
      chk($sformatf("v%0d_stall", i),    32'(st),           32'(vt[i].stall));
      chk($sformatf("v%0d_instr", i),    32'(ins),          32'(vt[i].instr));
      chk($sformatf("v%0d_hit_cnt", i),  32'(bus.hit_cnt),  32'(vt[i].hits));
      chk($sformatf("v%0d_miss_cnt", i), 32'(bus.miss_cnt), 32'(vt[i].misses));
      chk($sformatf("v%0d_requests", i), 32'(req_cnt),      32'(vt[i].misses));
    end

    // re=0: cache idles ready, nothing counted, no memory traffic.
    bus.re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("noreq_rdy",    32'(bus.rdy),    32'd1);
      chk("noreq_mem_re", 32'(bus.mem_re), 32'd0);
      chk("noreq_instr",  32'(bus.instr),  32'd0);
    end
    @(posedge clk);
    #1;
    chk("noreq_hit_cnt",  32'(bus.hit_cnt),  32'd13);
    chk("noreq_miss_cnt", 32'(bus.miss_cnt), 32'd6);

    // Flush during WAIT: the fill is dropped and the line is requested again.
    req0     = req_cnt;
    lat      = 3;
    bus.addr = 16'h0040;
    bus.re   = 1'b1;
    @(negedge clk);
    chk("wflush_first_rdy", 32'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("wflush_mem_re", 32'(bus.mem_re), 32'd1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    wait_rdy(st, ins);
    chk("wflush_stall",    32'(st),               32'd6);
    chk("wflush_instr",    32'(ins),              32'hC3E5);
    chk("wflush_requests", 32'(req_cnt - req0),   32'd2);
    chk("wflush_mem_addr", 32'(bus.mem_addr),     32'h0040);
    chk("wflush_hit_cnt",  32'(bus.hit_cnt),      32'd14);
    chk("wflush_miss_cnt", 32'(bus.miss_cnt),     32'd8);

    // Saturation of the hit counter.
    bus.re = 1'b0;
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFD;
    #1;
    release dut.hit_cnt_q;
    @(posedge clk);
    #1;
    do_access(16'h0041, 1'b0, 1, st, ins);
    chk("sat_instr",   32'(ins),          32'hC3E4);
    chk("sat_hit_1",   32'(bus.hit_cnt),  32'hFFFE);
    do_access(16'h0041, 1'b0, 1, st, ins);
    chk("sat_hit_2",   32'(bus.hit_cnt),  32'hFFFF);
    do_access(16'h0041, 1'b0, 1, st, ins);
    chk("sat_hit_3",   32'(bus.hit_cnt),  32'hFFFF);
    chk("sat_stall",   32'(st),           32'd0);
    chk("sat_miss",    32'(bus.miss_cnt), 32'd8);

    // Reset while a fill is outstanding; memory never answers this one.
    lat      = 1000;
    bus.addr = 16'h0060;
    bus.re   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstwait_mem_re",   32'(bus.mem_re),   32'd1);
    chk("rstwait_mem_addr", 32'(bus.mem_addr), 32'h0060);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait_mem_re_low",  32'(bus.mem_re),   32'd0);
    chk("rstwait_rdy_low",     32'(bus.rdy),      32'd0);
    chk("rstwait_mem_addr_0",  32'(bus.mem_addr), 32'd0);
    chk("rstwait_hit_cnt_0",   32'(bus.hit_cnt),  32'd0);
    chk("rstwait_miss_cnt_0",  32'(bus.miss_cnt), 32'd0);
    bus.re = 1'b0;
    lat    = 2;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req0 = req_cnt;
    do_access(16'h0041, 1'b0, 2, st, ins);
    chk("postrst_stall",    32'(st),             32'd3);
    chk("postrst_instr",    32'(ins),            32'hC3E4);
    chk("postrst_hit_cnt",  32'(bus.hit_cnt),    32'd1);
    chk("postrst_miss_cnt", 32'(bus.miss_cnt),   32'd1);
    chk("postrst_requests", 32'(req_cnt - req0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
